// File: rtl/nzcv_flag_unit_pkg.sv
// Shared NZCV definitions: flag vector type, bit positions (NCZV order) and ALU op encodings.
// The condition-enable evaluator imports this same package.
package nzcv_flag_unit_pkg;

  typedef logic [3:0] nzcv_t;

  localparam int FLG_N = 3;
  localparam int FLG_C = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ALU_LOGIC = 2'b00,
    ALU_ADD   = 2'b01,
    ALU_SUB   = 2'b10,
    ALU_MOVE  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/nzcv_flag_unit_calc.sv
// Combinational NZCV compute from one ALU result; V is carried through for
// logical/move ops so those instructions leave overflow untouched.
module nzcv_calc
  import nzcv_flag_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_res,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cout,
  input  logic             i_shc,
  input  logic [1:0]       i_alu_op,
  input  logic             i_prior_v,
  output nzcv_t            o_flags
);

  logic w_a_msb;
  logic w_b_msb;
  logic w_r_msb;

  assign w_a_msb = i_a[WIDTH-1];
  assign w_b_msb = i_b[WIDTH-1];
  assign w_r_msb = i_res[WIDTH-1];

  always_comb begin
    o_flags        = '0;
    o_flags[FLG_N] = w_r_msb;
    o_flags[FLG_Z] = (i_res == '0);
    case (alu_op_e'(i_alu_op))
      ALU_ADD: begin
        o_flags[FLG_C] = i_cout;
        o_flags[FLG_V] = (w_a_msb == w_b_msb) & (w_r_msb != w_a_msb);
      end
      ALU_SUB: begin
        // COUT is the no-borrow carry for subtraction
        o_flags[FLG_C] = i_cout;
        o_flags[FLG_V] = (w_a_msb != w_b_msb) & (w_r_msb != w_a_msb);
      end
      default: begin
        o_flags[FLG_C] = i_shc;
        o_flags[FLG_V] = i_prior_v;
      end
    endcase
  end

endmodule

// File: rtl/nzcv_flag_unit.sv
// NZCV status flag unit: capture computed flags into a pending stage, commit one
// cycle later, with forwarding, flush, stall and a highest-priority restore write.
module nzcv_flag_unit
  import nzcv_flag_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             VALID_IN,
  input  logic             SETF,
  input  logic [1:0]       ALU_OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] RES,
  input  logic             COUT,
  input  logic             SHC,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic             WR_EN,
  input  logic [3:0]       WR_DATA,
  output logic [3:0]       ALUF,
  output logic [3:0]       ALUF_FWD,
  output logic             PEND,
  output logic [15:0]      UPD_CNT
);

  nzcv_t       r_aluf;
  nzcv_t       r_pend_flags;
  logic        r_pend;
  logic [15:0] r_upd_cnt;
  nzcv_t       w_fwd;
  nzcv_t       w_calc_flags;

  // Forwarded view lets a back-to-back instruction see flags not yet committed
  assign w_fwd = r_pend ? r_pend_flags : r_aluf;

  nzcv_calc #(.WIDTH(WIDTH)) u_calc (
    .i_res    (RES),
    .i_a      (A),
    .i_b      (B),
    .i_cout   (COUT),
    .i_shc    (SHC),
    .i_alu_op (ALU_OP),
    .i_prior_v(w_fwd[FLG_V]),
    .o_flags  (w_calc_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aluf       <= '0;
      r_pend_flags <= '0;
      r_pend       <= 1'b0;
      r_upd_cnt    <= '0;
    end else if (WR_EN) begin
      r_aluf <= WR_DATA;
      r_pend <= 1'b0;
    end else if (FLUSH) begin
      r_pend <= 1'b0;
    end else if (!STALL) begin
      if (r_pend) begin
        r_aluf    <= r_pend_flags;
        r_upd_cnt <= r_upd_cnt + 16'd1;
      end
      if (VALID_IN && SETF) begin
        r_pend       <= 1'b1;
        r_pend_flags <= w_calc_flags;
      end else begin
        r_pend <= 1'b0;
      end
    end
  end

  assign ALUF     = r_aluf;
  assign ALUF_FWD = w_fwd;
  assign PEND     = r_pend;
  assign UPD_CNT  = r_upd_cnt;

endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Bench for nzcv_flag_unit: directed scenarios with fixed expected flags, then
// randomized traffic checked against an arithmetic reference model.
module tb_nzcv_flag_unit;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst;
  logic          VALID_IN, SETF, COUT, SHC, STALL, FLUSH, WR_EN;
  logic [1:0]    ALU_OP;
  logic [W-1:0]  A, B, RES;
  logic [3:0]    WR_DATA;
  logic [3:0]    ALUF, ALUF_FWD;
  logic          PEND;
  logic [15:0]   UPD_CNT;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [3:0]  m_aluf, m_pf;
  logic        m_pend;
  logic [15:0] m_cnt;

  nzcv_flag_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .VALID_IN(VALID_IN), .SETF(SETF), .ALU_OP(ALU_OP),
    .A(A), .B(B), .RES(RES), .COUT(COUT), .SHC(SHC), .STALL(STALL),
    .FLUSH(FLUSH), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .ALUF(ALUF),
    .ALUF_FWD(ALUF_FWD), .PEND(PEND), .UPD_CNT(UPD_CNT)
  );

  always #5 clk = ~clk;

  // Flags from the arithmetic meaning of the operation, not the msb formulas
  function automatic logic [3:0] ref_flags(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] res,
                                           input logic shc, input logic prior_v);
    logic [32:0] s;
    longint      r;
    logic        n, z, c, v;
    n = res[W-1];
    z = (res == 0);
    c = shc;
    v = prior_v;
    if (op == 2'b01) begin
      s = {1'b0, a} + {1'b0, b};
      c = s[32];
      r = longint'($signed(a)) + longint'($signed(b));
      v = (r > SMAX) || (r < SMIN);
    end else if (op == 2'b10) begin
      c = (a >= b);
      r = longint'($signed(a)) - longint'($signed(b));
      v = (r > SMAX) || (r < SMIN);
    end
    return {n, c, z, v};
  endfunction

  task automatic model_edge();
    logic [3:0] fwd;
    fwd = m_pend ? m_pf : m_aluf;
    if (rst) begin
      m_aluf = 0; m_pf = 0; m_pend = 0; m_cnt = 0;
    end else if (WR_EN) begin
      m_aluf = WR_DATA; m_pend = 0;
    end else if (FLUSH) begin
      m_pend = 0;
    end else if (!STALL) begin
      if (m_pend) begin
        m_aluf = m_pf;
        m_cnt  = m_cnt + 16'd1;
      end
      if (VALID_IN && SETF) begin
        m_pf   = ref_flags(ALU_OP, A, B, RES, SHC, fwd[0]);
        m_pend = 1;
      end else begin
        m_pend = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    VALID_IN = 0; SETF = 0; STALL = 0; FLUSH = 0; WR_EN = 0; WR_DATA = 0;
    ALU_OP = 0; A = 0; B = 0; RES = 0; COUT = 0; SHC = 0;
  endtask

  // Drive a self-consistent ALU result (RES and COUT derived from A, B)
  task automatic set_alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic shc, input logic setf);
    logic [32:0] s;
    VALID_IN = 1; SETF = setf; ALU_OP = op; A = a; B = b; SHC = shc;
    case (op)
      2'b01: begin s = {1'b0, a} + {1'b0, b}; RES = s[W-1:0]; COUT = s[32]; end
      2'b10: begin RES = a - b; COUT = (a >= b); end
      2'b00: begin RES = a & b; COUT = 0; end
      default: begin RES = b; COUT = 0; end
    endcase
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    m_aluf = 0; m_pf = 0; m_pend = 0; m_cnt = 0;
    #2;
    checks++;
    if ({ALUF, ALUF_FWD, PEND, UPD_CNT} !== 25'd0) begin
      errors++;
      $display("FAIL reset: got aluf=%b fwd=%b pend=%b cnt=%0d expected all zero",
               ALUF, ALUF_FWD, PEND, UPD_CNT);
    end
    tick();
    rst = 0;
  endtask

  task automatic test_add_overflow();
    set_alu(2'b01, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    tick();
    set_idle();
    checks++;
    if (ALUF_FWD !== 4'b1001 || PEND !== 1'b1 || ALUF !== 4'b0000) begin
      errors++;
      $display("FAIL add_ovf_fwd: got fwd=%b pend=%b aluf=%b expected fwd=1001 pend=1 aluf=0000",
               ALUF_FWD, PEND, ALUF);
    end
    tick();
    checks++;
    if (ALUF !== 4'b1001 || UPD_CNT !== 16'd1 || PEND !== 1'b0) begin
      errors++;
      $display("FAIL add_ovf_commit: got aluf=%b cnt=%0d pend=%b expected aluf=1001 cnt=1 pend=0",
               ALUF, UPD_CNT, PEND);
    end
  endtask

  task automatic test_sub_zero();
    set_alu(2'b10, 32'd5, 32'd5, 1'b0, 1'b1);
    tick();
    set_idle();
    tick();
    checks++;
    if (ALUF !== 4'b0110 || UPD_CNT !== 16'd2) begin
      errors++;
      $display("FAIL sub_zero: got aluf=%b cnt=%0d expected aluf=0110 cnt=2", ALUF, UPD_CNT);
    end
    set_alu(2'b01, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    tick();
    checks++;
    if (PEND !== 1'b0) begin
      errors++;
      $display("FAIL no_setf_pend: got pend=%b expected 0", PEND);
    end
    set_idle();
    tick();
    checks++;
    if (ALUF !== 4'b0110 || UPD_CNT !== 16'd2) begin
      errors++;
      $display("FAIL no_setf_aluf: got aluf=%b cnt=%0d expected aluf=0110 cnt=2", ALUF, UPD_CNT);
    end
  endtask

  task automatic test_back_to_back();
    set_alu(2'b01, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
    tick();
    set_alu(2'b00, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b1);
    tick();
    set_idle();
    checks++;
    if (ALUF !== 4'b1001 || ALUF_FWD !== 4'b0011 || PEND !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got aluf=%b fwd=%b pend=%b expected aluf=1001 fwd=0011 pend=1",
               ALUF, ALUF_FWD, PEND);
    end
    tick();
    checks++;
    if (ALUF !== 4'b0011 || UPD_CNT !== 16'd4) begin
      errors++;
      $display("FAIL b2b_second: got aluf=%b cnt=%0d expected aluf=0011 cnt=4", ALUF, UPD_CNT);
    end
  endtask

  task automatic test_flush_stall();
    set_alu(2'b01, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
    tick();
    set_idle();
    FLUSH = 1;
    tick();
    FLUSH = 0;
    checks++;
    if (PEND !== 1'b0 || ALUF_FWD !== 4'b0011 || ALUF !== 4'b0011) begin
      errors++;
      $display("FAIL flush: got pend=%b fwd=%b aluf=%b expected pend=0 fwd=0011 aluf=0011",
               PEND, ALUF_FWD, ALUF);
    end
    tick();
    checks++;
    if (ALUF !== 4'b0011 || UPD_CNT !== 16'd4) begin
      errors++;
      $display("FAIL flush_nocommit: got aluf=%b cnt=%0d expected aluf=0011 cnt=4", ALUF, UPD_CNT);
    end
    set_alu(2'b10, 32'd5, 32'd5, 1'b0, 1'b1);
    tick();
    set_alu(2'b01, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
    STALL = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ALUF !== 4'b0011 || PEND !== 1'b1 || ALUF_FWD !== 4'b0110 || UPD_CNT !== 16'd4) begin
        errors++;
        $display("FAIL stall_%0d: got aluf=%b pend=%b fwd=%b cnt=%0d expected 0011 1 0110 4",
                 i, ALUF, PEND, ALUF_FWD, UPD_CNT);
      end
    end
    set_idle();
    tick();
    checks++;
    if (ALUF !== 4'b0110 || UPD_CNT !== 16'd5 || PEND !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got aluf=%b cnt=%0d pend=%b expected 0110 5 0",
               ALUF, UPD_CNT, PEND);
    end
  endtask

  task automatic test_restore();
    set_alu(2'b01, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
    tick();
    set_alu(2'b10, 32'd5, 32'd5, 1'b0, 1'b1);
    WR_EN = 1; WR_DATA = 4'b1111;
    tick();
    set_idle();
    checks++;
    if (ALUF !== 4'b1111 || PEND !== 1'b0 || UPD_CNT !== 16'd5) begin
      errors++;
      $display("FAIL restore: got aluf=%b pend=%b cnt=%0d expected 1111 0 5", ALUF, PEND, UPD_CNT);
    end
    tick();
    checks++;
    if (ALUF !== 4'b1111 || UPD_CNT !== 16'd5) begin
      errors++;
      $display("FAIL restore_hold: got aluf=%b cnt=%0d expected 1111 5", ALUF, UPD_CNT);
    end
  endtask

  task automatic test_async_reset();
    set_alu(2'b10, 32'd5, 32'd5, 1'b0, 1'b1);
    tick();
    tick();
    checks++;
    if (ALUF !== 4'b0110 || PEND !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got aluf=%b pend=%b expected 0110 1", ALUF, PEND);
    end
    set_idle();
    #2;
    rst = 1;
    m_aluf = 0; m_pf = 0; m_pend = 0; m_cnt = 0;
    #1;
    checks++;
    if ({ALUF, ALUF_FWD, PEND, UPD_CNT} !== 25'd0) begin
      errors++;
      $display("FAIL async_reset: got aluf=%b fwd=%b pend=%b cnt=%0d expected all zero",
               ALUF, ALUF_FWD, PEND, UPD_CNT);
    end
    tick();
    rst = 0;
    set_alu(2'b01, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
    tick();
    set_idle();
    tick();
    checks++;
    if (ALUF !== 4'b1001 || UPD_CNT !== 16'd1) begin
      errors++;
      $display("FAIL post_reset: got aluf=%b cnt=%0d expected 1001 1", ALUF, UPD_CNT);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 400; i++) begin
      set_idle();
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? a : $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h7FFF_FFFF;
        1: a = 32'h8000_0000;
        default: ;
      endcase
      set_alu(2'($urandom_range(0, 3)), a, b, 1'($urandom), ($urandom_range(0, 9) < 7));
      VALID_IN = ($urandom_range(0, 9) < 8);
      STALL    = ($urandom_range(0, 9) < 2);
      FLUSH    = ($urandom_range(0, 12) == 0);
      WR_EN    = ($urandom_range(0, 24) == 0);
      WR_DATA  = 4'($urandom);
      tick();
      checks++;
      if (ALUF !== m_aluf || ALUF_FWD !== (m_pend ? m_pf : m_aluf) ||
          PEND !== m_pend || UPD_CNT !== m_cnt) begin
        errors++;
        $display("FAIL random_%0d: got aluf=%b fwd=%b pend=%b cnt=%0d expected aluf=%b fwd=%b pend=%b cnt=%0d",
                 i, ALUF, ALUF_FWD, PEND, UPD_CNT, m_aluf, (m_pend ? m_pf : m_aluf), m_pend, m_cnt);
      end
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_back_to_back();
    test_flush_stall();
    test_restore();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nzcv_flag_unit.md
Name: nzcv_flag_unit

Overview:
Produces the NZCV status flags that the condition-enable evaluator consumes on its ALUF input. It computes N/Z/C/V from each ALU result, captures them in a pending stage when the instruction's S bit is set, and commits them to the architectural flag register one cycle later. It also provides a forwarded flag view for back-to-back condition checks, a flush for squashed instructions, and a direct restore-write path.

Parameters:
WIDTH, 32, ALU datapath width in bits (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
VALID_IN  in  1  ALU result valid this cycle
SETF  in  1  instruction S bit; flags update requested
ALU_OP  in  2  00 logical, 01 add, 10 sub, 11 move/shift
A  in  WIDTH  operand A
B  in  WIDTH  operand B (after shifter)
RES  in  WIDTH  ALU result
COUT  in  1  adder carry-out (sub: 1 = no borrow)
SHC  in  1  shifter carry-out
STALL  in  1  pipeline hold
FLUSH  in  1  squash the uncommitted flag update
WR_EN  in  1  restore write (MSR/exception return)
WR_DATA  in  4  flags to restore, NCZV order
ALUF  out  4  committed flags, registered
ALUF_FWD  out  4  forwarded flags, combinational: PEND ? PEND_FLAGS : ALUF
PEND  out  1  uncommitted update in flight
UPD_CNT  out  16  count of committed updates, wraps

Behaviour:
- Bit order everywhere is NCZV: [3]=N, [2]=C, [1]=Z, [0]=V.
- Flag compute (combinational, msb = WIDTH-1):
  - N = RES[msb]
  - Z = (RES == 0)
  - C: add/sub use COUT; logical/move use SHC.
  - V, add: (A[msb]==B[msb]) & (RES[msb]!=A[msb]).
  - V, sub: (A[msb]!=B[msb]) & (RES[msb]!=A[msb]).
  - V, logical/move: ALUF_FWD[0], i.e. V is preserved.
- Capture, evaluated when STALL=0:
  - VALID_IN & SETF & ~FLUSH: PEND<=1, PEND_FLAGS<=computed.
  - Otherwise: PEND<=0.
- Commit: when PEND=1 and STALL=0, ALUF<=PEND_FLAGS and UPD_CNT<=UPD_CNT+1, both on the same edge as the next capture.
- Latency:
  - ALUF_FWD reflects an update 1 cycle after VALID_IN.
  - ALUF reflects it 2 cycles after VALID_IN.
- Back-to-back captures are legal every cycle. When a capture and a commit coincide, the old pending value commits and the new one becomes pending.
- STALL=1 freezes PEND, PEND_FLAGS, ALUF and UPD_CNT. VALID_IN is ignored.
- FLUSH=1:
  - PEND<=0 and the pending flags are discarded; ALUF is unchanged.
  - Overrides a same-cycle capture.
  - Overrides STALL.
- WR_EN=1, highest priority:
  - ALUF<=WR_DATA and PEND<=0.
  - Overrides STALL, FLUSH, commit and capture.
  - UPD_CNT is not incremented.
- rst=1 (any time, asynchronous): ALUF=0000, PEND=0, PEND_FLAGS=0000, UPD_CNT=0. The first edge after deassertion behaves normally.
- UPD_CNT wraps from 16'hFFFF to 0.

Decomposition:
- Shared package: typedef for the 4-bit NCZV flag vector; bit-index constants FLG_N=3, FLG_C=2, FLG_Z=1, FLG_V=0; ALU_OP encodings. The condition-enable evaluator uses the same package.
- Sub-module: nzcv_calc, purely combinational flag compute (RES, A, B, COUT, SHC, ALU_OP, prior V -> 4-bit flags).
- Pending/commit registers and priority logic stay in the top.

Test Plan:
1. ADD 0x7FFFFFFF+0x00000001, RES=0x80000000, COUT=0, SETF=1:
   - Cycle +1: ALUF_FWD=1001, PEND=1.
   - Cycle +2: ALUF=1001, UPD_CNT=1.
2. SUB 5-5, RES=0, COUT=1, SETF=1 -> ALUF=0110 after 2 cycles. Repeat with SETF=0 -> ALUF unchanged, PEND stays 0.
3. Logical after state 1001, RES=0, SHC=0 -> new flags 0011 (V preserved). Issued back-to-back with step 1 -> ALUF goes 1001 then 0011 on consecutive cycles.
4. Capture 1001, then FLUSH on the next cycle:
   - ALUF_FWD reverts to the prior ALUF.
   - ALUF never becomes 1001 and UPD_CNT does not increment.
   - STALL held for 3 cycles with PEND=1: ALUF frozen, commits on the first cycle after release.
5. WR_EN=1, WR_DATA=1111, with PEND=1 and a same-cycle capture -> ALUF=1111, PEND=0, UPD_CNT unchanged.
6. rst asserted asynchronously mid-cycle with PEND=1 and ALUF=0110 -> all outputs 0 immediately. After release, a capture commits normally 2 cycles later.
